// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/gnt/rvalid data-bus master with alignment and load extension.
// Optional bus-timeout watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memread_MEM,
   input  logic        memwrite_MEM,
   input  logic [2:0]  funct3_MEM,
   input  logic [31:0] alu_out_MEM,
   input  logic [31:0] store_data_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] dataread_MEM,
   output logic        mem_stall,
   output logic        misalign_MEM,
   output logic        bus_err_MEM
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned BEW  = XLEN / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // The counter must be able to represent TIMEOUT.
   if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_cnt_w_check
      $error("mem_access_unit: CNT_W too narrow for TIMEOUT");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT_R = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [BEW-1:0]    be_q, be_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdres_q, rdres_d;
   logic              misalign_q, misalign_d;
   logic              bus_err_q, bus_err_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;

   logic              op_c;
   logic              aligned_c;
   logic [1:0]        off_c;
   logic [BEW-1:0]    be_c;
   logic [XLEN-1:0]   wdata_c;
   logic [XLEN-1:0]   shifted_c;
   logic [XLEN-1:0]   load_c;
   logic              expire_c;

`ifdef MEM_TIMEOUT_EN
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign expire_c = (cnt_q >= CNT_W'(TIMEOUT - 1));
`else
   assign expire_c = 1'b0;
`endif

   assign op_c  = memread_MEM | memwrite_MEM;
   assign off_c = alu_out_MEM[1:0];

   // Alignment check, byte enables and lane-replicated store data.
   always_comb begin
      aligned_c = 1'b0;
      be_c      = '0;
      wdata_c   = store_data_MEM;
      case (funct3_MEM)
         F3_B, F3_BU: begin
            aligned_c = 1'b1;
            be_c      = BEW'(4'b0001 << off_c);
            wdata_c   = {4{store_data_MEM[7:0]}};
         end
         F3_H, F3_HU: begin
            aligned_c = ~off_c[0];
            be_c      = BEW'(4'b0011 << off_c);
            wdata_c   = {2{store_data_MEM[15:0]}};
         end
         F3_W: begin
            aligned_c = (off_c == 2'b00);
            be_c      = 4'b1111;
         end
         default: begin
            aligned_c = 1'b0;
         end
      endcase
   end

   // Lane select and sign/zero extension of the returned word.
   always_comb begin
      shifted_c = dmem_rdata >> {off_q, 3'b000};
      case (f3_q)
         F3_B:    load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
         F3_BU:   load_c = {24'h0, shifted_c[7:0]};
         F3_H:    load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
         F3_HU:   load_c = {16'h0, shifted_c[15:0]};
         default: load_c = dmem_rdata;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdres_d    = rdres_q;
      off_d      = off_q;
      f3_d       = f3_q;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      mem_stall  = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (op_c) begin
               mem_stall = 1'b1;
               if (aligned_c) begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  we_d    = memwrite_MEM & ~memread_MEM;
                  addr_d  = {alu_out_MEM[31:2], 2'b00};
                  be_d    = be_c;
                  wdata_d = wdata_c;
                  off_d   = off_c;
                  f3_d    = funct3_MEM;
`ifdef MEM_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  state_d    = S_DONE;
                  misalign_d = 1'b1;
                  rdres_d    = '0;
               end
            end
         end

         S_REQ: begin
            mem_stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
            cnt_d     = cnt_q + CNT_W'(1);
`endif
            if (dmem_gnt) begin
               req_d   = 1'b0;
               state_d = we_q ? S_DONE : S_WAIT_R;
            end else if (expire_c) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               rdres_d   = '0;
               state_d   = S_DONE;
            end
         end

         S_WAIT_R: begin
            mem_stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
            cnt_d     = cnt_q + CNT_W'(1);
`endif
            if (dmem_rvalid) begin
               rdres_d = load_c;
               state_d = S_DONE;
            end else if (expire_c) begin
               bus_err_d = 1'b1;
               rdres_d   = '0;
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rdres_q    <= '0;
         off_q      <= '0;
         f3_q       <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdres_q    <= rdres_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_be      = be_q;
   assign dmem_wdata   = wdata_q;
   assign dataread_MEM = rdres_q;
   assign misalign_MEM = misalign_q;
   assign bus_err_MEM  = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit; timeout vectors run only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memread_MEM, memwrite_MEM;
   logic [2:0]  funct3_MEM;
   logic [31:0] alu_out_MEM, store_data_MEM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [31:0] dataread_MEM;
   logic        mem_stall, misalign_MEM, bus_err_MEM;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM),
      .funct3_MEM(funct3_MEM), .alu_out_MEM(alu_out_MEM),
      .store_data_MEM(store_data_MEM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .dataread_MEM(dataread_MEM), .mem_stall(mem_stall),
      .misalign_MEM(misalign_MEM), .bus_err_MEM(bus_err_MEM)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [31:0] rdata;
      int          gnt_dly;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] data;
      logic        mis;
      logic        err;
      int          stall;
      int          reqs;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [31:0] rdata, input int gnt_dly,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic we, input logic [31:0] data,
                               input logic mis, input logic err,
                               input int stall, input int reqs);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2;
      v.rdata = rdata; v.gnt_dly = gnt_dly; v.be = be; v.wdata = wdata;
      v.we = we; v.data = data; v.mis = mis; v.err = err;
      v.stall = stall; v.reqs = reqs;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_req"},   32'(dmem_req),     32'h0);
      chk({tag, "_we"},    32'(dmem_we),      32'h0);
      chk({tag, "_addr"},  dmem_addr,         32'h0);
      chk({tag, "_be"},    32'(dmem_be),      32'h0);
      chk({tag, "_wdata"}, dmem_wdata,        32'h0);
      chk({tag, "_data"},  dataread_MEM,      32'h0);
      chk({tag, "_mis"},   32'(misalign_MEM), 32'h0);
      chk({tag, "_err"},   32'(bus_err_MEM),  32'h0);
      chk({tag, "_stall"}, 32'(mem_stall),    32'h0);
   endtask

   // Drives one access, plays the bus slave, and checks the DONE-cycle results.
   task automatic run_vec(input string tag, input vec_t v);
      int          stall_n, req_n;
      logic        rv_pend, done, stable;
      logic [3:0]  be_s;
      logic [31:0] wd_s, ad_s, d_s, exp_addr;
      logic        we_s, mis_s, err_s;
      stall_n = 0; req_n = 0; rv_pend = 1'b0; done = 1'b0; stable = 1'b1;
      be_s = '0; wd_s = '0; ad_s = '0; we_s = 1'b0;
      d_s = '0; mis_s = 1'b0; err_s = 1'b0;
      @(posedge clk); #1;
      memread_MEM = v.rd; memwrite_MEM = v.wr; funct3_MEM = v.f3;
      alu_out_MEM = v.addr; store_data_MEM = v.rs2;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
         if (!mem_stall) begin
            done  = 1'b1;
            d_s   = dataread_MEM;
            mis_s = misalign_MEM;
            err_s = bus_err_MEM;
         end else begin
            stall_n++;
            if (dmem_req) begin
               req_n++;
               if (req_n == 1) begin
                  be_s = dmem_be; wd_s = dmem_wdata; ad_s = dmem_addr; we_s = dmem_we;
               end else if (be_s !== dmem_be || wd_s !== dmem_wdata ||
                            ad_s !== dmem_addr || we_s !== dmem_we) begin
                  stable = 1'b0;
               end
               if (req_n > v.gnt_dly) begin
                  dmem_gnt = 1'b1;
                  rv_pend  = v.rd;
               end
            end else if (rv_pend) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = v.rdata;
               rv_pend     = 1'b0;
            end
         end
      end
      chk({tag, "_done_reached"}, 32'(done), 32'h1);
      exp_addr = (v.reqs > 0) ? {v.addr[31:2], 2'b00} : 32'h0;
      chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(v.stall));
      chk({tag, "_req_cycles"},   32'(req_n),   32'(v.reqs));
      chk({tag, "_be"},           32'(be_s),    32'(v.be));
      chk({tag, "_wdata"},        wd_s,         v.wdata);
      chk({tag, "_we"},           32'(we_s),    32'(v.we));
      chk({tag, "_addr"},         ad_s,         exp_addr);
      chk({tag, "_stable"},       32'(stable),  32'h1);
      chk({tag, "_dataread"},     d_s,          v.data);
      chk({tag, "_misalign"},     32'(mis_s),   32'(v.mis));
      chk({tag, "_bus_err"},      32'(err_s),   32'(v.err));
      // Pipeline advances past DONE: instruction leaves MEM, flags must clear.
      @(posedge clk); #1;
      memread_MEM = 1'b0; memwrite_MEM = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_stall"}, 32'(mem_stall),    32'h0);
      chk({tag, "_idle_req"},   32'(dmem_req),     32'h0);
      chk({tag, "_idle_mis"},   32'(misalign_MEM), 32'h0);
      chk({tag, "_idle_err"},   32'(bus_err_MEM),  32'h0);
      chk({tag, "_idle_data"},  dataread_MEM,      v.data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      memread_MEM = 1'b0; memwrite_MEM = 1'b0; funct3_MEM = 3'b000;
      alu_out_MEM = '0; store_data_MEM = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

      //          rd wr f3      addr          rs2           rdata         gd  be     wdata         we data          mis err st rq
      vecs.push_back(mk(1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'hF, 32'h0,        0, 32'hDEADBEEF, 0, 0, 3, 1));
      vecs.push_back(mk(1, 0, 3'b000, 32'h203, 32'h0,        32'h80112233, 0, 4'h8, 32'h0,        0, 32'hFFFFFF80, 0, 0, 3, 1));
      vecs.push_back(mk(1, 0, 3'b100, 32'h203, 32'h0,        32'h80112233, 0, 4'h8, 32'h0,        0, 32'h00000080, 0, 0, 3, 1));
      vecs.push_back(mk(1, 0, 3'b101, 32'h202, 32'h0,        32'h80112233, 0, 4'hC, 32'h0,        0, 32'h00008011, 0, 0, 3, 1));
      vecs.push_back(mk(1, 0, 3'b001, 32'h202, 32'h0,        32'h80112233, 0, 4'hC, 32'h0,        0, 32'hFFFF8011, 0, 0, 3, 1));
      vecs.push_back(mk(1, 0, 3'b000, 32'h200, 32'h0,        32'h80112233, 0, 4'h1, 32'h0,        0, 32'h00000033, 0, 0, 3, 1));
      vecs.push_back(mk(1, 0, 3'b001, 32'h200, 32'h0,        32'h1234F00D, 0, 4'h3, 32'h0,        0, 32'hFFFFF00D, 0, 0, 3, 1));
      vecs.push_back(mk(0, 1, 3'b001, 32'h306, 32'h0000ABCD, 32'h0,        3, 4'hC, 32'hABCDABCD, 1, 32'hFFFFF00D, 0, 0, 5, 4));
      vecs.push_back(mk(0, 1, 3'b000, 32'h401, 32'h123456A5, 32'h0,        1, 4'h2, 32'hA5A5A5A5, 1, 32'hFFFFF00D, 0, 0, 3, 2));
      vecs.push_back(mk(0, 1, 3'b010, 32'h500, 32'hCAFEF00D, 32'h0,        0, 4'hF, 32'hCAFEF00D, 1, 32'hFFFFF00D, 0, 0, 2, 1));
      vecs.push_back(mk(1, 0, 3'b100, 32'h201, 32'h0,        32'h80112233, 0, 4'h2, 32'h0,        0, 32'h00000022, 0, 0, 3, 1));
      vecs.push_back(mk(1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h203, 32'h0,        32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        1, 0, 1, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h502, 32'h12345678, 32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 3'b011, 32'h700, 32'h0,        32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 3'b110, 32'h700, 32'h0,        32'h0,        0, 4'h0, 32'h0,        0, 32'h0,        1, 0, 1, 0));
      vecs.push_back(mk(1, 1, 3'b010, 32'h600, 32'h0,        32'h0BADF00D, 0, 4'hF, 32'h0,        0, 32'h0BADF00D, 0, 0, 3, 1));
      vecs.push_back(mk(1, 0, 3'b010, 32'h704, 32'h0,        32'h55AA55AA, 2, 4'hF, 32'h0,        0, 32'h55AA55AA, 0, 0, 5, 3));
      vecs.push_back(mk(0, 1, 3'b000, 32'h003, 32'h000000FE, 32'h0,        0, 4'h8, 32'hFEFEFEFE, 1, 32'h55AA55AA, 0, 0, 2, 1));
`ifdef MEM_TIMEOUT_EN
      vecs.push_back(mk(1, 0, 3'b010, 32'h800, 32'h0,        32'h0,       99, 4'hF, 32'h0,        0, 32'h0,        0, 1, 17, 16));
      vecs.push_back(mk(0, 1, 3'b010, 32'h804, 32'h00000001, 32'h0,       15, 4'hF, 32'h00000001, 1, 32'h0,        0, 0, 17, 16));
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec($sformatf("v%0d", i), vecs[i]);
      end

      // rvalid coinciding with gnt must be ignored; the later rvalid supplies the data.
      @(posedge clk); #1;
      memread_MEM = 1'b1; funct3_MEM = 3'b010; alu_out_MEM = 32'h900;
      @(negedge clk);
      chk("gr_idle_stall", 32'(mem_stall), 32'h1);
      @(negedge clk);
      chk("gr_req", 32'(dmem_req), 32'h1);
      dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      chk("gr_wait_stall", 32'(mem_stall), 32'h1);
      chk("gr_wait_req",   32'(dmem_req),  32'h0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h22222222;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("gr_done_stall", 32'(mem_stall), 32'h0);
      chk("gr_done_data",  dataread_MEM,   32'h22222222);
      @(posedge clk); #1;
      memread_MEM = 1'b0;

      // Reset while waiting for read data abandons the transaction.
      @(posedge clk); #1;
      memread_MEM = 1'b1; funct3_MEM = 3'b010; alu_out_MEM = 32'h800;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req", 32'(dmem_req), 32'h1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("rst_wait_stall", 32'(mem_stall), 32'h1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      memread_MEM = 1'b0;
      @(negedge clk);
      chk_idle_zero("rst_mid");
      rst_n = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk_idle_zero("rst_late_rvalid");
      run_vec("rst_after",
              mk(1, 0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 0, 4'hF, 32'h0, 0,
                 32'h13579BDF, 0, 0, 3, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit that sits directly upstream of the MEM/WB pipeline register.
- Takes the EX/MEM control, address and store data, and runs a req/gnt/rvalid transaction on the data-memory bus.
- Performs byte/half/word alignment and sign/zero extension, and produces dataread_MEM for MEM/WB.
- Asserts mem_stall to freeze the pipeline while a transaction is in flight.

Parameters:
- TIMEOUT, 16, cycles allowed in REQ+WAIT_R before a bus error; used only with MEM_TIMEOUT_EN.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- memread_MEM  in  1  load in MEM stage.
- memwrite_MEM  in  1  store in MEM stage.
- funct3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_out_MEM  in  32  byte address.
- store_data_MEM  in  32  rs2 value.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, {alu_out_MEM[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read word.
- dataread_MEM  out  32  extended load result, registered.
- mem_stall  out  1  freeze IF..MEM, combinational.
- misalign_MEM  out  1  misaligned access flag, registered.
- bus_err_MEM  out  1  timeout flag, registered.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, dataread_MEM, misalign_MEM, bus_err_MEM all go to 0; counter goes to 0.
  - Reset mid-transaction abandons it. A later gnt or rvalid seen in IDLE is ignored.
- op = memread_MEM | memwrite_MEM. If both are 1, treat as a load.
- States:
  - IDLE: if op and aligned, latch addr/be/wdata/we, set dmem_req=1, go to REQ. If op and misaligned, go to DONE with misalign_MEM=1, dataread_MEM=0 and no bus activity.
  - REQ: hold dmem_req and all bus outputs stable until dmem_gnt=1. On gnt, drop req; a store goes to DONE, a load goes to WAIT_R.
  - WAIT_R: on dmem_rvalid, extract and extend the result into dataread_MEM, go to DONE. rvalid is only sampled here; rvalid in the same cycle as gnt (while in REQ) is ignored.
  - DONE: lasts one cycle with mem_stall=0, so MEM/WB captures dataread_MEM at the end of it. Then go to IDLE. misalign_MEM and bus_err_MEM are valid only in DONE and clear on leaving it.
- mem_stall = (IDLE & op) | REQ | WAIT_R.
- Non-memory instructions see mem_stall=0 in IDLE. dataread_MEM holds its last value.
- Alignment:
  - Halfword needs addr[0]=0.
  - Word needs addr[1:0]=00.
  - Reserved funct3 values (011, 110, 111) are treated as misaligned.
- Store byte enables and data:
  - SB: be = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
- Loads: select byte or half by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU). Loads drive dmem_be the same way as stores.
- Minimum latency: a store stalls 2 cycles and a load stalls 3 cycles, given gnt on the first REQ cycle and rvalid on the first WAIT_R cycle.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter clears on entering REQ and increments in REQ and WAIT_R.
  - When the count reaches TIMEOUT, drop dmem_req and go to DONE with bus_err_MEM=1 and dataread_MEM=0.
  - If rvalid or gnt arrives in the same cycle as expiry, the response wins.
- MEM_TIMEOUT_EN undefined: no counter, the unit waits indefinitely, and bus_err_MEM is tied to 0.

Test Plan:
- LW addr 0x100, gnt in REQ cycle 1, rvalid=0xDEADBEEF one cycle later -> dmem_be=1111, mem_stall high exactly 3 cycles, DONE shows dataread_MEM=0xDEADBEEF.
- LB addr 0x203, rdata=0x80112233 -> 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU addr 0x202 -> 0x00008011.
- SH addr 0x306, rs2=0x0000ABCD, gnt delayed 3 cycles -> req/be=1100/wdata=0xABCDABCD stable throughout, mem_stall high 5 cycles, we=1.
- LW addr 0x101 -> no dmem_req, misalign_MEM=1 in DONE, dataread_MEM=0, mem_stall high 1 cycle.
- rst_n low while in WAIT_R, then rvalid arrives -> state IDLE, all outputs 0, rvalid ignored, next LW completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT=16, gnt never asserted -> req drops after 16 cycles, bus_err_MEM=1 in DONE; a second run with gnt arriving on the expiry cycle -> normal completion.
